// File: rtl/duck_pkg.sv
// Shared game types and constants for the duck-hunt sequencer and the
// colour mapper that consumes its state.
package duck_pkg;

  typedef enum logic [2:0] {
    TITLE     = 3'd0,
    INTRO     = 3'd1,
    PLAY      = 3'd2,
    GAMEOVER  = 3'd3,
    ROUND_END = 3'd4
  } game_state_t;

  localparam int SCORE_MAX = 99;
  localparam int FCNT_W    = 10;

  // Score increment that sticks at the two-digit display limit.
  function automatic logic [7:0] score_inc(input logic [7:0] s);
    return (s >= 8'(SCORE_MAX)) ? s : s + 8'd1;
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector on an already-synchronized level, one-cycle history.
module rise_detect (
  input  logic Clk,
  input  logic Reset,
  input  logic d,
  output logic rise
);

  logic r_q;

  // Previous-cycle sample of the input level.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_q <= 1'b0;
    end else begin
      r_q <= d;
    end
  end

  assign rise = d & ~r_q;

endmodule

// File: rtl/game_sequencer.sv
// Game flow controller: title, dog intro, play with shot/hit resolution,
// round end and game over, all paced by frame ticks.
module game_sequencer
  import duck_pkg::*;
#(
  parameter int INTRO_FRAMES    = 180,
  parameter int ROUND_FRAMES    = 600,
  parameter int SHOT_FRAMES     = 4,
  parameter int END_FRAMES      = 120,
  parameter int SHOTS_PER_ROUND = 3,
  parameter int ROUNDS          = 10
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       start_btn,
  input  logic       trigger,
  input  logic       hit_pixel,
  output logic [2:0] state,
  output logic       shot,
  output logic       duck_hit,
  output logic [1:0] shots_left,
  output logic [7:0] score,
  output logic [3:0] round_num
);

  localparam logic [FCNT_W-1:0] INTRO_LAST = FCNT_W'(INTRO_FRAMES - 1);
  localparam logic [FCNT_W-1:0] ROUND_LAST = FCNT_W'(ROUND_FRAMES - 1);
  localparam logic [FCNT_W-1:0] END_LAST   = FCNT_W'(END_FRAMES - 1);
  localparam logic [FCNT_W-1:0] FCNT_MAX   = {FCNT_W{1'b1}};
  localparam logic [3:0]        SHOT_LOAD  = 4'(SHOT_FRAMES);
  localparam logic [1:0]        SHOTS_INIT = 2'(SHOTS_PER_ROUND);
  localparam logic [3:0]        ROUND_MAX  = 4'(ROUNDS);

  game_state_t       r_state;
  logic              r_shot;
  logic              r_duck_hit;
  logic [1:0]        r_shots_left;
  logic [7:0]        r_score;
  logic [3:0]        r_round;
  logic [FCNT_W-1:0] r_fcnt;
  logic [3:0]        r_scnt;

  logic              w_start_rise;
  logic              w_trig_rise;
  logic [FCNT_W-1:0] w_fcnt_inc;
  logic              w_timeout;

  rise_detect u_start_rise (
    .Clk   (Clk),
    .Reset (Reset),
    .d     (start_btn),
    .rise  (w_start_rise)
  );

  rise_detect u_trig_rise (
    .Clk   (Clk),
    .Reset (Reset),
    .d     (trigger),
    .rise  (w_trig_rise)
  );

  assign w_fcnt_inc = (r_fcnt == FCNT_MAX) ? r_fcnt : r_fcnt + 10'd1;
  // Past the last round frame means a timeout was deferred behind a shot.
  assign w_timeout  = (frame_tick && (r_fcnt == ROUND_LAST)) || (r_fcnt > ROUND_LAST);

  // Game state machine with all outputs held in registers.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_state      <= TITLE;
      r_shot       <= 1'b0;
      r_duck_hit   <= 1'b0;
      r_shots_left <= SHOTS_INIT;
      r_score      <= 8'd0;
      r_round      <= 4'd1;
      r_fcnt       <= '0;
      r_scnt       <= 4'd0;
    end else begin
      r_state      <= r_state;
      r_shot       <= r_shot;
      r_duck_hit   <= r_duck_hit;
      r_shots_left <= r_shots_left;
      r_score      <= r_score;
      r_round      <= r_round;
      r_scnt       <= r_scnt;
      r_fcnt       <= frame_tick ? w_fcnt_inc : r_fcnt;
      case (r_state)
        TITLE: begin
          if (w_start_rise) begin
            r_state    <= INTRO;
            r_fcnt     <= '0;
            r_score    <= 8'd0;
            r_round    <= 4'd1;
            r_duck_hit <= 1'b0;
          end
        end
        INTRO: begin
          if (frame_tick && (r_fcnt == INTRO_LAST)) begin
            r_state      <= PLAY;
            r_fcnt       <= '0;
            r_shots_left <= SHOTS_INIT;
            r_duck_hit   <= 1'b0;
          end
        end
        PLAY: begin
          if (!r_shot && (r_duck_hit || (r_shots_left == 2'd0) || w_timeout)) begin
            r_state <= ROUND_END;
            r_fcnt  <= '0;
          end else if (r_shot) begin
            // Flash window closes on the tick that takes the counter to zero.
            if (frame_tick) begin
              r_scnt <= r_scnt - 4'd1;
              if (r_scnt == 4'd1) begin
                r_shot <= 1'b0;
              end
            end
            if (hit_pixel && !r_duck_hit) begin
              r_duck_hit <= 1'b1;
              r_score    <= score_inc(r_score);
            end
          end else if (w_trig_rise && (r_shots_left != 2'd0) && !r_duck_hit) begin
            r_shot       <= 1'b1;
            r_scnt       <= SHOT_LOAD;
            r_shots_left <= r_shots_left - 2'd1;
          end
        end
        ROUND_END: begin
          if (frame_tick && (r_fcnt == END_LAST)) begin
            r_fcnt <= '0;
            if (!r_duck_hit || (r_round == ROUND_MAX)) begin
              r_state <= GAMEOVER;
            end else begin
              r_state    <= INTRO;
              r_round    <= r_round + 4'd1;
              r_duck_hit <= 1'b0;
            end
          end
        end
        GAMEOVER: begin
          if (w_start_rise) begin
            r_state <= TITLE;
            r_fcnt  <= '0;
          end
        end
        default: begin
          r_state <= TITLE;
          r_fcnt  <= '0;
          r_shot  <= 1'b0;
          r_scnt  <= 4'd0;
        end
      endcase
    end
  end

  assign state      = r_state;
  assign shot       = r_shot;
  assign duck_hit   = r_duck_hit;
  assign shots_left = r_shots_left;
  assign score      = r_score;
  assign round_num  = r_round;

endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
- Top-level game controller that drives the 3-bit state, shot and score inputs consumed by color_mapper and the sprite logic.
- Sequences title -> dog intro -> play -> round end -> game over, counting in frame ticks.
- Resolves trigger pulls against the per-pixel hit signal and maintains the score, shots left and round number.
- Sits beside color_mapper in the top level, clocked by the 50 MHz Clk.

Parameters:
- INTRO_FRAMES, 180, frames spent in INTRO (dog walk) before PLAY (1..1023).
- ROUND_FRAMES, 600, maximum PLAY frames before the duck escapes (1..1023).
- SHOT_FRAMES, 4, frames the shot flash/hit window stays open (1..15).
- END_FRAMES, 120, frames spent in ROUND_END (1..1023).
- SHOTS_PER_ROUND, 3, shots granted per round (1..3).
- ROUNDS, 10, rounds per game (1..15).

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-low reset.
- frame_tick  in  1  one-Clk pulse per frame at vsync start.
- start_btn  in  1  synchronized start button level, active-high.
- trigger  in  1  synchronized gun trigger level, active-high.
- hit_pixel  in  1  high while the pixel being drawn is both cursor and non-transparent duck.
- state  out  3  game_state_t, encoded 0=TITLE 1=INTRO 2=PLAY 3=GAMEOVER 4=ROUND_END.
- shot  out  1  shot flash active (drives color_mapper shot).
- duck_hit  out  1  duck hit this round, held until next INTRO.
- shots_left  out  2  remaining shots in round.
- score  out  8  binary hits, saturates at 99.
- round_num  out  4  current round, 1-based.

Behaviour:
- Clocking and reset:
  - All state is registered on posedge Clk.
  - Reset low (checked only on a Clk edge) forces: state=TITLE, shot=0, duck_hit=0, shots_left=SHOTS_PER_ROUND, score=0, round_num=1, frame counter=0, shot counter=0, edge registers=0.
  - A reset mid-operation takes effect on the next edge with no residue.
- Edge detection: start_rise = start_btn & ~start_q and trig_rise = trigger & ~trig_q. Each uses a 1-cycle registered history.
- Frame counter (fcnt, 10 bit):
  - Increments on frame_tick only.
  - Clears on every state change.
  - Compare against the parameter minus 1 at the tick, so exactly N ticks elapse in the state.
- TITLE: on start_rise -> INTRO with score=0, round_num=1, duck_hit=0.
- INTRO: on frame_tick with fcnt==INTRO_FRAMES-1 -> PLAY, loading shots_left=SHOTS_PER_ROUND and duck_hit=0.
- PLAY, shot start:
  - A shot is accepted when trig_rise, shot==0, shots_left!=0 and duck_hit==0.
  - Next cycle: shot=1, shot counter=SHOT_FRAMES, shots_left decremented.
- PLAY, shot counter: decrements on frame_tick while shot=1. When it goes 1 -> 0, shot=0 in the same update.
- PLAY, shot overlap:
  - A trig_rise while shot=1 is ignored.
  - trig_rise and frame_tick in the same cycle: the load wins and that tick does not decrement.
- PLAY, hit:
  - hit_pixel while shot=1 and duck_hit=0 sets duck_hit=1 next cycle and increments score (saturating 99).
  - At most one hit is counted per shot.
  - hit_pixel in the same cycle as the accepting trig_rise is not counted.
- PLAY exit -> ROUND_END, evaluated only when shot==0, on the first cycle any of these holds:
  - duck_hit=1;
  - shots_left==0;
  - frame_tick with fcnt==ROUND_FRAMES-1 (duck escaped).
- PLAY exit timing:
  - A round timeout while shot=1 is deferred until shot falls.
  - fcnt saturates at 1023 while deferred.
- ROUND_END: after END_FRAMES ticks:
  - duck_hit==0 -> GAMEOVER;
  - else round_num==ROUNDS -> GAMEOVER;
  - else round_num increments -> INTRO.
- GAMEOVER: start_rise -> TITLE. Score is held for display until then.
- Outputs are registered. state changes one Clk after the qualifying input. Undefined state encodings (5-7) recover to TITLE.

Decomposition:
- Package duck_pkg holds:
  - typedef enum logic [2:0] game_state_t with the encodings above;
  - localparam SCORE_MAX=99;
  - FCNT_W=10.
- color_mapper will import game_state_t in a later change.
- One sub-module: rise_detect (Clk, Reset, d, rise), instantiated for start_btn and trigger.

Test Plan:
- Bench overrides: INTRO=3, ROUND=20, SHOT=2, END=2, SHOTS=3, ROUNDS=2.
- Reset low 2 cycles mid-PLAY -> state=0, score=0, shots_left=3, round_num=1, shot=0 on the first edge after release.
- start_rise in TITLE, then 3 ticks -> state 0->1->2. State is 2 exactly one cycle after the 3rd tick. shots_left=3.
- In PLAY: trigger pulse, hit_pixel high 1 cycle one cycle later -> shot=1 for 2 ticks, duck_hit=1, score=1, shots_left=2.
  - Second trigger while shot=1 is ignored.
  - After shot falls: state=4, then after 2 ticks state=1, round_num=2.
- 3 triggers with no hit_pixel -> shots_left 3->2->1->0, score=0. After the last shot falls: state=4, then 2 ticks -> state=3. start_rise -> state=0.
- trigger held high 10 cycles -> exactly one shot accepted.
- trig_rise and frame_tick in the same cycle -> shot counter=2 and still lasts 2 further ticks.
- Round timeout: 20 ticks in PLAY, with a shot active at the 20th tick -> state stays 2 until shot=0, then 4. duck_hit=0 -> GAMEOVER after END.
- Score saturation: preload to 99 by forcing, then a hit -> score stays 99, duck_hit=1.
